// File: rtl/vending_pkg.sv
// Shared coin codes, price and acceptor state encoding for the vending front end.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_1    = 2'd1;
  localparam logic [1:0] COIN_2    = 2'd2;

  localparam logic [2:0] PRICE       = 3'd3;
  localparam int         QUEUE_DEPTH = 3;

  typedef logic [1:0] acc_state_t;
  localparam acc_state_t COLLECT = 2'd0;
  localparam acc_state_t SEND    = 2'd1;
  localparam acc_state_t GAP     = 2'd2;
  localparam acc_state_t REFUND  = 2'd3;

  // Queue entries are 1 bit: 0 = one-unit coin, 1 = two-unit coin.
  function automatic logic [2:0] coin_value(input logic two_unit);
    return two_unit ? 3'd2 : 3'd1;
  endfunction

  function automatic logic [1:0] coin_code(input logic two_unit);
    return two_unit ? COIN_2 : COIN_1;
  endfunction

endpackage

// File: rtl/coin_sync_edge.sv
// Slot sensor synchroniser with a one-cycle pulse on each rising level.
module coin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sensor,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   last_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg <= '0;
      last_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], sensor};
      last_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  // Decoded from flops only, so the pulse is clean for the FSM.
  assign rise = sync_reg[SYNC_STAGES-1] & ~last_reg;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: queues coins until the price is met, replays them to the
// vending machine, checks its pr/ch reply, and refunds on cancel.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       slot1,
  input  logic       slot2,
  input  logic       cancel,
  input  logic       pr,
  input  logic       ch,
  output logic [1:0] coin,
  output logic [2:0] credit,
  output logic       busy,
  output logic       reject,
  output logic       refund1,
  output logic       refund2,
  output logic       err
);

  logic rise1;
  logic rise2;

  coin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk    (clk),
    .rstn   (rstn),
    .sensor (slot1),
    .rise   (rise1)
  );

  coin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
    .clk    (clk),
    .rstn   (rstn),
    .sensor (slot2),
    .rise   (rise2)
  );

  acc_state_t             state_reg,   state_next;
  logic [QUEUE_DEPTH-1:0] queue_reg,   queue_next;
  logic [1:0]             count_reg,   count_next;
  logic [1:0]             idx_reg,     idx_next;
  logic [2:0]             credit_reg,  credit_next;
  logic [1:0]             coin_reg,    coin_next;
  logic                   reject_reg,  reject_next;
  logic                   refund1_reg, refund1_next;
  logic                   refund2_reg, refund2_next;
  logic                   err_reg,     err_next;

  logic       sel_entry;
  logic       new_two;
  logic [2:0] credit_sum;

  // Entry addressed by idx_reg; idx can reach QUEUE_DEPTH, which selects 0.
  always_comb begin
    sel_entry = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (idx_reg == 2'(i)) sel_entry = queue_reg[i];
    end
  end

  assign new_two    = rise2;
  assign credit_sum = credit_reg + coin_value(new_two);

  always_comb begin
    state_next   = state_reg;
    queue_next   = queue_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    credit_next  = credit_reg;
    coin_next    = COIN_NONE;
    reject_next  = 1'b0;
    refund1_next = 1'b0;
    refund2_next = 1'b0;
    err_next     = err_reg;

    case (state_reg)
      COLLECT: begin
        if (cancel) begin
          reject_next = rise1 | rise2;
          if (count_reg != 2'd0) begin
            state_next = REFUND;
            idx_next   = 2'd0;
          end
        end else if (rise1 | rise2) begin
          // A simultaneous pair keeps the two-unit coin.
          reject_next = rise1 & rise2;
          for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (count_reg == 2'(i)) queue_next[i] = new_two;
          end
          count_next  = count_reg + 2'd1;
          credit_next = credit_sum;
          if (credit_sum >= PRICE) begin
            state_next = SEND;
            coin_next  = coin_code(queue_reg[0]);
            idx_next   = 2'd1;
          end
        end
      end

      SEND: begin
        reject_next = rise1 | rise2;
        if (idx_reg < count_reg) begin
          coin_next = coin_code(sel_entry);
          idx_next  = idx_reg + 2'd1;
        end else begin
          state_next = GAP;
        end
      end

      GAP: begin
        reject_next = rise1 | rise2;
        if (!pr || (ch != (credit_reg == 3'd4))) err_next = 1'b1;
        state_next  = COLLECT;
        queue_next  = '0;
        count_next  = 2'd0;
        idx_next    = 2'd0;
        credit_next = 3'd0;
      end

      default: begin  // REFUND
        reject_next  = rise1 | rise2;
        refund1_next = ~sel_entry;
        refund2_next = sel_entry;
        credit_next  = credit_reg - coin_value(sel_entry);
        if (idx_reg == count_reg - 2'd1) begin
          state_next = COLLECT;
          queue_next = '0;
          count_next = 2'd0;
          idx_next   = 2'd0;
        end else begin
          idx_next = idx_reg + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= COLLECT;
      queue_reg   <= '0;
      count_reg   <= 2'd0;
      idx_reg     <= 2'd0;
      credit_reg  <= 3'd0;
      coin_reg    <= COIN_NONE;
      reject_reg  <= 1'b0;
      refund1_reg <= 1'b0;
      refund2_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      queue_reg   <= queue_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      credit_reg  <= credit_next;
      coin_reg    <= coin_next;
      reject_reg  <= reject_next;
      refund1_reg <= refund1_next;
      refund2_reg <= refund2_next;
      err_reg     <= err_next;
    end
  end

  assign coin    = coin_reg;
  assign credit  = credit_reg;
  assign busy    = (state_reg != COLLECT);
  assign reject  = reject_reg;
  assign refund1 = refund1_reg;
  assign refund2 = refund2_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a behavioural vending machine on pr/ch
// and a queue-based scoreboard for coin, reject and refund events.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rstn;
  logic       slot1, slot2, cancel;
  logic       pr, ch;
  logic [1:0] coin;
  logic [2:0] credit;
  logic       busy, reject, refund1, refund2, err;

  coin_acceptor #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .slot1   (slot1),
    .slot2   (slot2),
    .cancel  (cancel),
    .pr      (pr),
    .ch      (ch),
    .coin    (coin),
    .credit  (credit),
    .busy    (busy),
    .reject  (reject),
    .refund1 (refund1),
    .refund2 (refund2),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  bit tb_done  = 0;
  bit force_bad = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Vending machine: accumulates coins, PRODUCT for one cycle once price is met.
  logic [2:0] vm_sum;
  logic       vm_prod, vm_change;
  logic [2:0] vm_add;
  assign vm_add = vm_sum + 3'(coin);

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vm_sum <= 3'd0; vm_prod <= 1'b0; vm_change <= 1'b0;
    end else if (vm_prod) begin
      vm_prod <= 1'b0; vm_change <= 1'b0;
    end else if (vm_add >= 3'd3) begin
      vm_prod <= 1'b1; vm_change <= (vm_add == 3'd4); vm_sum <= 3'd0;
    end else begin
      vm_sum <= vm_add;
    end
  end

  assign pr = vm_prod & ~force_bad;
  assign ch = vm_prod & vm_change;

  typedef struct {
    logic [1:0] val;
    bit         first;
  } coin_exp_t;

  coin_exp_t exp_coin[$];
  int        exp_refund[$];
  bit        exp_reject[$];
  int        last_coin_cycle = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, req);
    end
  endtask

  task automatic push_coin(input logic [1:0] v, input bit first);
    coin_exp_t e;
    e.val = v;
    e.first = first;
    exp_coin.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    coin_exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && !tb_done) begin
        if (coin != 2'd0) begin
          if (exp_coin.size() == 0) begin
            check("coin_unexpected", int'(coin), 0);
          end else begin
            e = exp_coin.pop_front();
            check("coin_value", int'(coin), int'(e.val));
            if (!e.first) check("coin_consecutive", cycle, last_coin_cycle + 1);
          end
          last_coin_cycle = cycle;
          $display("cycle %0d: coin=%0d credit=%0d", cycle, coin, credit);
        end
        if (reject) begin
          if (exp_reject.size() == 0) check("reject_unexpected", int'(reject), 0);
          else begin
            void'(exp_reject.pop_front());
            n_checks++;
          end
          $display("cycle %0d: reject pulse", cycle);
        end
        if (refund1 || refund2) begin
          if (exp_refund.size() == 0) check("refund_unexpected", int'({refund2, refund1}), 0);
          else check("refund_kind", int'({refund2, refund1}), exp_refund.pop_front());
          $display("cycle %0d: refund1=%0d refund2=%0d", cycle, refund1, refund2);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d, expected completion", cycle);
    $fatal(1, "timeout");
  end

  // One coin: sensor high for two samples, credit/busy checked right after enqueue.
  task automatic coin_in(input bit s1, input bit s2, input int exp_credit,
                         input bit exp_busy, input int idle);
    @(negedge clk); slot1 = s1; slot2 = s2;
    @(negedge clk);
    @(negedge clk); slot1 = 1'b0; slot2 = 1'b0;
    @(negedge clk);
    check("credit", int'(credit), exp_credit);
    check("busy", int'(busy), int'(exp_busy));
    $display("cycle %0d: coin in s1=%0d s2=%0d credit=%0d busy=%0d", cycle, s1, s2, credit, busy);
    repeat (idle) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_coin"},    int'(coin),    0);
    check({tag, "_credit"},  int'(credit),  0);
    check({tag, "_busy"},    int'(busy),    0);
    check({tag, "_reject"},  int'(reject),  0);
    check({tag, "_refund1"}, int'(refund1), 0);
    check({tag, "_refund2"}, int'(refund2), 0);
    check({tag, "_err"},     int'(err),     0);
  endtask

  initial begin
    rstn = 1'b0; slot1 = 1'b0; slot2 = 1'b0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1+1+1
    push_coin(2'd1, 1); push_coin(2'd1, 0); push_coin(2'd1, 0);
    coin_in(1, 0, 1, 0, 2);
    coin_in(1, 0, 2, 0, 2);
    coin_in(1, 0, 3, 1, 2);
    repeat (3) @(negedge clk);
    check("t1_credit_after", int'(credit), 0);
    check("t1_busy_after", int'(busy), 0);
    check("t1_err", int'(err), 0);

    // 2+2 with change
    push_coin(2'd2, 1); push_coin(2'd2, 0);
    coin_in(0, 1, 2, 0, 2);
    coin_in(0, 1, 4, 1, 2);
    repeat (3) @(negedge clk);
    check("t2_credit_after", int'(credit), 0);
    check("t2_err", int'(err), 0);

    // 1+2, then a slot1 arriving while busy
    push_coin(2'd1, 1); push_coin(2'd2, 0);
    exp_reject.push_back(1'b1);
    coin_in(1, 0, 1, 0, 2);
    coin_in(0, 1, 3, 1, 0);
    slot1 = 1'b1;
    repeat (2) @(negedge clk);
    slot1 = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_credit_after", int'(credit), 0);
    check("t3_busy_after", int'(busy), 0);
    check("t3_err", int'(err), 0);

    // slot2 then cancel
    exp_refund.push_back(2);
    coin_in(0, 1, 2, 0, 2);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("t4_busy_refund", int'(busy), 1);
    @(negedge clk);
    check("t4_credit_after", int'(credit), 0);
    check("t4_busy_after", int'(busy), 0);
    repeat (2) @(negedge clk);

    // Simultaneous rises, then slot1 completes 2,1
    exp_reject.push_back(1'b1);
    push_coin(2'd2, 1); push_coin(2'd1, 0);
    coin_in(1, 1, 2, 0, 2);
    coin_in(1, 0, 3, 1, 2);
    repeat (3) @(negedge clk);
    check("t5_credit_after", int'(credit), 0);
    check("t5_err", int'(err), 0);

    // Bad vend response sets err
    force_bad = 1'b1;
    push_coin(2'd1, 1); push_coin(2'd2, 0);
    coin_in(1, 0, 1, 0, 2);
    coin_in(0, 1, 3, 1, 2);
    repeat (3) @(negedge clk);
    check("t6_err_set", int'(err), 1);
    force_bad = 1'b0;

    // Reset mid-SEND: only the first coin is ever presented
    push_coin(2'd2, 1);
    coin_in(0, 1, 2, 0, 2);
    coin_in(0, 1, 4, 1, 0);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    #2 rstn = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("post_reset");

    tb_done = 1'b1;
    check("coin_leftover", exp_coin.size(), 0);
    check("reject_leftover", exp_reject.size(), 0);
    check("refund_leftover", exp_refund.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
